fetch_unit: RTL and testbench

Instruction fetch stage for the 16-bit processor. It holds the program counter, reads 16-bit instructions from instruction memory over a request/acknowledge handshake, and presents each instruction to decode and the immediate generator. The instruction and its PC are held stable until the downstream stage accepts them. A one-cycle redirect input loads a new PC for branches and jumps. A memory request that is already in flight is completed and its data discarded.

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage for the 16-bit processor. It holds the program
// counter and reads 16-bit instruction words from instruction memory over a
// request/acknowledge handshake. Each fetched word is presented to decode
// together with its PC. Both are held until the downstream stage accepts them.
// A one-cycle redirect loads a new fetch PC for branches and jumps. A memory
// request that is already in flight runs to completion, and its data is
// discarded.
//
// Parameters
//   RESET_PC    PC loaded at reset
//   PC_STEP     PC increment per instruction (byte-addressed 16-bit words)
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   stall        in   downstream not accepting; hold the presented instruction
//   redirect     in   one-cycle pulse: fetch next from redirect_pc
//   redirect_pc  in   [15:0] redirect target
//   mem_req      out  instruction memory read request
//   mem_addr     out  [15:0] read address (registered)
//   mem_ack      in   memory returns mem_rdata this cycle
//   mem_rdata    in   [15:0] instruction word
//   inst         out  [15:0] fetched instruction
//   inst_pc      out  [15:0] PC of inst
//   inst_valid   out  inst / inst_pc are valid
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] inst,
   output logic [15:0] inst_pc,
   output logic        inst_valid
);

   // FLUSH waits out a request whose data must be dropped. pc already holds
   // the redirect target, and addr_q still holds the old request address.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state, state_d;
   logic [15:0] pc, pc_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] inst_d, inst_pc_d;
   logic        inst_valid_d;

   // mem_addr always comes from a register, so the request address cannot
   // glitch while a request is outstanding.
   assign mem_addr = addr_q;

   // NOTE: sequential state uses non-blocking assignments only. Every
   // register takes its value from the *_d signals, so the order of the
   // statements in this block does not matter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         addr_q     <= RESET_PC;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else begin
         state      <= state_d;
         pc         <= pc_d;
         addr_q     <= addr_d;
         inst       <= inst_d;
         inst_pc    <= inst_pc_d;
         inst_valid <= inst_valid_d;
      end
   end

   // NOTE: every signal written here gets a default first. Branches that do
   // not mention a signal therefore hold its value, and no latch is inferred.
   always_comb begin
      state_d      = state;
      pc_d         = pc;
      addr_d       = addr_q;
      inst_d       = inst;
      inst_pc_d    = inst_pc;
      inst_valid_d = inst_valid;
      mem_req      = 1'b0;

      case (state)
         IDLE: begin
            if (redirect) begin
               pc_d   = redirect_pc;
               addr_d = redirect_pc;
            end
            state_d = FETCH;
         end

         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack && redirect) begin
               // The data has arrived but is stale. Re-issue the request at
               // the target in the next cycle.
               pc_d   = redirect_pc;
               addr_d = redirect_pc;
            end else if (mem_ack) begin
               inst_d       = mem_rdata;
               inst_pc_d    = pc;
               pc_d         = pc + PC_STEP;   // wraps modulo 2^16
               inst_valid_d = 1'b1;
               state_d      = HOLD;
            end else if (redirect) begin
               // The request must finish at its old address. Remember the
               // target in pc and drain the request in FLUSH.
               pc_d    = redirect_pc;
               state_d = FLUSH;
            end
         end

         FLUSH: begin
            mem_req = 1'b1;
            if (redirect) begin
               pc_d = redirect_pc;            // the last redirect wins
            end
            if (mem_ack) begin
               addr_d  = redirect ? redirect_pc : pc;
               state_d = FETCH;
            end
         end

         HOLD: begin
            if (redirect) begin
               inst_valid_d = 1'b0;
               pc_d         = redirect_pc;
               addr_d       = redirect_pc;
               state_d      = FETCH;
            end else if (!stall) begin
               inst_valid_d = 1'b0;
               addr_d       = pc;
               state_d      = FETCH;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit, run in three phases:
//   1. A vector table applied cycle by cycle. It covers the zero-wait fetch
//      pair, wait states, a stall, a redirect from HOLD, a redirect together
//      with an ack, a FLUSH where the last redirect wins, FLUSH with a
//      redirect and an ack together, and the PC wrap at 0xFFFE.
//   2. A hand-written sequence: reset asserted while a request is in flight,
//      then a redirect in IDLE.
//   3. Random stall, redirect and memory-wait stimulus, checked against a
//      program-flow model. The next accepted instruction's PC is the last
//      redirect target, or else the previous PC + 2. Its word is mem_word(pc).
//      An unacked request must hold its address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_valid;

   int n_total = 0;
   int n_pass  = 0;

   fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
      .clock       (clock),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Contents of the instruction memory used in the random phase.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5AC3;
   endfunction

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [15:0] rpc;
      logic        ack;
      logic [15:0] rdata;
      logic        req;
      logic [15:0] addr;
      logic [15:0] inst;
      logic [15:0] ipc;
      logic        valid;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rpc,
                               input logic a, input logic [15:0] d,
                               input logic req, input logic [15:0] addr,
                               input logic [15:0] i, input logic [15:0] ipc, input logic v);
      vec_t t;
      t.stall = s; t.redirect = r; t.rpc = rpc; t.ack = a; t.rdata = d;
      t.req = req; t.addr = addr; t.inst = i; t.ipc = ipc; t.valid = v;
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [32];
      logic [15:0] exp_pc;
      logic        pending;
      logic [15:0] pend_addr;
      int          consumed;

      // Each row gives the inputs for one cycle and the expected outputs after that edge.
      tbl[0]  = mk(0,0,16'h0000,0,16'h0000, 1,16'h0000,16'h0000,16'h0000,0);
      tbl[1]  = mk(0,0,16'h0000,1,16'h9696, 0,16'h0000,16'h9696,16'h0000,1);
      tbl[2]  = mk(0,0,16'h0000,0,16'h0000, 1,16'h0002,16'h9696,16'h0000,0);
      tbl[3]  = mk(0,0,16'h0000,1,16'h4B65, 0,16'h0002,16'h4B65,16'h0002,1);
      tbl[4]  = mk(0,0,16'h0000,0,16'h0000, 1,16'h0004,16'h4B65,16'h0002,0);
      tbl[5]  = mk(0,0,16'h0000,0,16'h0000, 1,16'h0004,16'h4B65,16'h0002,0);
      tbl[6]  = mk(0,0,16'h0000,0,16'h0000, 1,16'h0004,16'h4B65,16'h0002,0);
      tbl[7]  = mk(0,0,16'h0000,1,16'h25F8, 0,16'h0004,16'h25F8,16'h0004,1);
      tbl[8]  = mk(1,0,16'h0000,0,16'h0000, 0,16'h0004,16'h25F8,16'h0004,1);
      tbl[9]  = mk(1,0,16'h0000,0,16'h0000, 0,16'h0004,16'h25F8,16'h0004,1);
      tbl[10] = mk(1,0,16'h0000,1,16'hFFFF, 0,16'h0004,16'h25F8,16'h0004,1);
      tbl[11] = mk(1,0,16'h0000,0,16'h0000, 0,16'h0004,16'h25F8,16'h0004,1);
      tbl[12] = mk(1,0,16'h0000,0,16'h0000, 0,16'h0004,16'h25F8,16'h0004,1);
      tbl[13] = mk(0,0,16'h0000,0,16'h0000, 1,16'h0006,16'h25F8,16'h0004,0);
      tbl[14] = mk(0,0,16'h0000,1,16'h1234, 0,16'h0006,16'h1234,16'h0006,1);
      tbl[15] = mk(1,1,16'h0100,0,16'h0000, 1,16'h0100,16'h1234,16'h0006,0);
      tbl[16] = mk(0,0,16'h0000,1,16'hABCD, 0,16'h0100,16'hABCD,16'h0100,1);
      tbl[17] = mk(0,0,16'h0000,0,16'h0000, 1,16'h0102,16'hABCD,16'h0100,0);
      tbl[18] = mk(0,1,16'h0010,1,16'h7777, 1,16'h0010,16'hABCD,16'h0100,0);
      tbl[19] = mk(0,1,16'h0200,0,16'h0000, 1,16'h0010,16'hABCD,16'h0100,0);
      tbl[20] = mk(0,0,16'h0000,0,16'h0000, 1,16'h0010,16'hABCD,16'h0100,0);
      tbl[21] = mk(0,0,16'h0000,1,16'hF359, 1,16'h0200,16'hABCD,16'h0100,0);
      tbl[22] = mk(0,0,16'h0000,1,16'h5A5A, 0,16'h0200,16'h5A5A,16'h0200,1);
      tbl[23] = mk(0,1,16'hFFFE,0,16'h0000, 1,16'hFFFE,16'h5A5A,16'h0200,0);
      tbl[24] = mk(0,0,16'h0000,1,16'h0E0E, 0,16'hFFFE,16'h0E0E,16'hFFFE,1);
      tbl[25] = mk(0,0,16'h0000,0,16'h0000, 1,16'h0000,16'h0E0E,16'hFFFE,0);
      tbl[26] = mk(0,1,16'h0300,0,16'h0000, 1,16'h0000,16'h0E0E,16'hFFFE,0);
      tbl[27] = mk(0,1,16'h0400,0,16'h0000, 1,16'h0000,16'h0E0E,16'hFFFE,0);
      tbl[28] = mk(0,0,16'h0000,1,16'h9999, 1,16'h0400,16'h0E0E,16'hFFFE,0);
      tbl[29] = mk(0,1,16'h0500,0,16'h0000, 1,16'h0400,16'h0E0E,16'hFFFE,0);
      tbl[30] = mk(0,1,16'h0600,1,16'h8888, 1,16'h0600,16'h0E0E,16'hFFFE,0);
      tbl[31] = mk(0,0,16'h0000,1,16'h1357, 0,16'h0600,16'h1357,16'h0600,1);

      // ---------------- reset state ----------------
      @(negedge clock);
      @(negedge clock);
      check("reset mem_req",    32'(mem_req),    32'h0);
      check("reset inst_valid", 32'(inst_valid), 32'h0);
      check("reset mem_addr",   32'(mem_addr),   32'h0);
      check("reset inst",       32'(inst),       32'h0);
      check("reset inst_pc",    32'(inst_pc),    32'h0);
      reset = 1'b1;

      // ---------------- table phase ----------------
      for (int i = 0; i < 32; i++) begin
         stall = tbl[i].stall; redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
         mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
         @(posedge clock);
         #1;
         check($sformatf("row%0d mem_req", i),    32'(mem_req),    32'(tbl[i].req));
         check($sformatf("row%0d mem_addr", i),   32'(mem_addr),   32'(tbl[i].addr));
         check($sformatf("row%0d inst", i),       32'(inst),       32'(tbl[i].inst));
         check($sformatf("row%0d inst_pc", i),    32'(inst_pc),    32'(tbl[i].ipc));
         check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
         @(negedge clock);
      end

      // ---------------- reset in flight, then redirect in IDLE ----------------
      stall = 0; redirect = 0; mem_ack = 0;
      @(posedge clock);
      #1;
      check("pre-reset mem_req",  32'(mem_req),  32'h1);
      check("pre-reset mem_addr", 32'(mem_addr), 32'h0602);
      #2;
      reset = 1'b0;                         // asserted away from any clock edge
      #1;
      check("async reset mem_req",    32'(mem_req),    32'h0);
      check("async reset inst_valid", 32'(inst_valid), 32'h0);
      check("async reset mem_addr",   32'(mem_addr),   32'h0);
      check("async reset inst",       32'(inst),       32'h0);
      @(posedge clock);
      #1;
      check("held reset mem_req", 32'(mem_req), 32'h0);
      @(negedge clock);
      reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h0800;
      @(posedge clock);
      #1;
      check("idle redirect mem_req",  32'(mem_req),  32'h1);
      check("idle redirect mem_addr", 32'(mem_addr), 32'h0800);
      @(negedge clock);
      redirect = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2468;
      @(posedge clock);
      #1;
      check("idle redirect inst",    32'(inst),       32'h2468);
      check("idle redirect inst_pc", 32'(inst_pc),    32'h0800);
      check("idle redirect valid",   32'(inst_valid), 32'h1);
      @(negedge clock);
      mem_ack = 1'b0;

      // ---------------- randomized phase ----------------
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      exp_pc   = 16'h0000;
      pending  = 1'b0;
      pend_addr = '0;
      consumed = 0;
      for (int c = 0; c < 4000; c++) begin
         // Outputs are stable here, midway between rising edges.
         if (pending) begin
            check("rand request held", {15'(0), mem_req, mem_addr}, {15'(0), 1'b1, pend_addr});
         end
         if (inst_valid) begin
            check("rand inst_pc",        32'(inst_pc), 32'(exp_pc));
            check("rand inst",           32'(inst),    32'(mem_word(exp_pc)));
            check("rand no req in hold", 32'(mem_req), 32'h0);
         end

         stall       = ($urandom_range(0, 9) < 3);
         redirect    = ($urandom_range(0, 99) < 8);
         redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
         mem_ack     = ($urandom_range(0, 9) < 6);
         mem_rdata   = mem_req ? mem_word(mem_addr) : 16'($urandom);

         if (redirect) begin
            exp_pc = redirect_pc;
         end else if (inst_valid && !stall) begin
            exp_pc = exp_pc + 16'd2;
            consumed++;
         end
         pending   = mem_req && !mem_ack;
         pend_addr = mem_addr;
         @(negedge clock);
      end
      check("rand progress", 32'(consumed >= 200), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
